// File: rtl/gpr_file_mp.sv
// gpr_file_mp: multi-port general-purpose register file.
//
// Two write ports (port 1 wins on an address clash), NUM_READ registered read
// ports with write-through bypass, and a clear sequencer that zeroes the
// storage array after every reset. The storage array itself has no reset.
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   write_enable0/1       write valids (port 1 has priority)
//   write_addr0/1         write addresses
//   write_data0/1         write data
//   read_enable           per-port read valid, bit i = port i
//   read_addr             packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   read_data             packed registered read data, port i at [i*DATA_W +: DATA_W]
//   init_busy             high while the clear sequencer runs

// One read port: computes the next read value and registers it.
module gpr_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_active,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_raw,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] rd_nxt;

  // Priority chain: clear/disabled -> hardwired zero -> port 1 bypass ->
  // port 0 bypass -> stored value. The zero-register test sits ahead of
  // the bypass so address 0 never forwards write data.
  always_comb begin
    rd_nxt = '0;
    if (clr_active || !rd_en)
      rd_nxt = '0;
    else if (ZERO_REG != 0 && rd_addr == '0)
      rd_nxt = '0;
    else if (wr_en1 && wr_addr1 == rd_addr)
      rd_nxt = wr_data1;
    else if (wr_en0 && wr_addr0 == rd_addr)
      rd_nxt = wr_data0;
    else
      rd_nxt = rd_raw;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_nxt;
  end
endmodule

module gpr_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         write_enable0,
  input  logic [$clog2(DEPTH)-1:0]     write_addr0,
  input  logic [DATA_W-1:0]            write_data0,
  input  logic                         write_enable1,
  input  logic [$clog2(DEPTH)-1:0]     write_addr1,
  input  logic [DATA_W-1:0]            write_data1,
  input  logic [NUM_READ-1:0]          read_enable,
  input  logic [NUM_READ*$clog2(DEPTH)-1:0] read_addr,
  output logic [NUM_READ*DATA_W-1:0]   read_data,
  output logic                         init_busy
);
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_active;

  logic [DATA_W-1:0] regs [DEPTH];

  logic [NUM_READ-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_READ-1:0][DATA_W-1:0] rd_raw;
  logic [NUM_READ-1:0][DATA_W-1:0] rd_q;

  logic wr0_ok, wr1_ok;

  assign clr_active = (state == ST_INIT);

  // Clear sequencer: one entry per cycle, leaves INIT on the edge that
  // clears the last entry so init_busy is high for exactly DEPTH cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else if (state == ST_INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
        state     <= ST_READY;
        init_busy <= 1'b0;
      end
    end
  end

  // Writes to a hardwired-zero register 0 are dropped at the array.
  assign wr0_ok = write_enable0 && !(ZERO_REG != 0 && write_addr0 == '0);
  assign wr1_ok = write_enable1 && !(ZERO_REG != 0 && write_addr1 == '0);

  // Port 1 is written after port 0 so it wins on an equal address.
  // External writes are ignored while clearing.
  always_ff @(posedge clock) begin
    if (clr_active) begin
      regs[clr_cnt] <= '0;
    end else begin
      if (wr0_ok) regs[write_addr0] <= write_data0;
      if (wr1_ok) regs[write_addr1] <= write_data1;
    end
  end

  assign rd_addr   = read_addr;
  assign read_data = rd_q;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    assign rd_raw[i] = regs[rd_addr[i]];

    gpr_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clock      (clock),
      .reset      (reset),
      .clr_active (clr_active),
      .rd_en      (read_enable[i]),
      .rd_addr    (rd_addr[i]),
      .rd_raw     (rd_raw[i]),
      .wr_en0     (write_enable0),
      .wr_addr0   (write_addr0),
      .wr_data0   (write_data0),
      .wr_en1     (write_enable1),
      .wr_addr1   (write_addr1),
      .wr_data1   (write_data1),
      .rd_data    (rd_q[i])
    );
  end
endmodule

// File: tb/tb_gpr_file_mp.sv
// Bench for gpr_file_mp: two instances (ZERO_REG=1 and ZERO_REG=0) share one
// stimulus stream; expected read data for both is queued as each vector is
// driven and compared after the following rising edge.
module tb_gpr_file_mp;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int NR     = 2;
  localparam int AW     = 5;

  logic              clock;
  logic              reset;
  logic              we0, we1;
  logic [AW-1:0]     wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic [NR-1:0]     re;
  logic [AW-1:0]     ra0, ra1;
  logic [NR*DATA_W-1:0] rd_z1, rd_z0;
  logic              busy_z1, busy_z0;

  int n_chk  = 0;
  int n_fail = 0;

  gpr_file_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_READ(NR), .ZERO_REG(1)) dut_z1 (
    .clock(clock), .reset(reset),
    .write_enable0(we0), .write_addr0(wa0), .write_data0(wd0),
    .write_enable1(we1), .write_addr1(wa1), .write_data1(wd1),
    .read_enable(re), .read_addr({ra1, ra0}),
    .read_data(rd_z1), .init_busy(busy_z1)
  );

  gpr_file_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_READ(NR), .ZERO_REG(0)) dut_z0 (
    .clock(clock), .reset(reset),
    .write_enable0(we0), .write_addr0(wa0), .write_data0(wd0),
    .write_enable1(we1), .write_addr1(wa1), .write_data1(wd1),
    .read_enable(re), .read_addr({ra1, ra0}),
    .read_data(rd_z0), .init_busy(busy_z0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DATA_W-1:0] wd1;
    logic [NR-1:0]     re;
    logic [AW-1:0]     ra0;
    logic [AW-1:0]     ra1;
    logic [DATA_W-1:0] e0, e1;   // expected, ZERO_REG=1 instance
    logic [DATA_W-1:0] f0, f1;   // expected, ZERO_REG=0 instance
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] e0, e1, f0, f1;
  } exp_t;

  localparam int NV = 13;
  vec_t vec [NV];
  exp_t sb [$];

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    re = '0; ra0 = '0; ra1 = '0;
  endtask

  // Counts edges until init_busy falls; read data must stay zero throughout.
  task automatic run_init(input string tag);
    int cnt;
    cnt = 0;
    chk({tag, "_busy_at_release"}, {31'd0, busy_z1}, 32'd1);
    while (busy_z1 && cnt < 100) begin
      cnt++;
      @(posedge clock); #1;
      chk({tag, "_rd_z1_p0"}, rd_z1[0*DATA_W +: DATA_W], '0);
      chk({tag, "_rd_z1_p1"}, rd_z1[1*DATA_W +: DATA_W], '0);
      chk({tag, "_rd_z0_p0"}, rd_z0[0*DATA_W +: DATA_W], '0);
    end
    chk({tag, "_len"}, cnt, 32'd32);
    chk({tag, "_z0_busy_done"}, {31'd0, busy_z0}, 32'd0);
  endtask

  initial begin
    exp_t x;

    //           we0 wa0   wd0           we1 wa1   wd1           re     ra0    ra1    e0            e1            f0            f1
    vec[0]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       2'b11, 5'd5,  5'd9,  32'h0,        32'h0,        32'h0,        32'h0};
    vec[1]  = '{1'b1, 5'd3, 32'hDEADBEEF,1'b0, 5'd0, 32'h0,       2'b00, 5'd3,  5'd3,  32'h0,        32'h0,        32'h0,        32'h0};
    vec[2]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       2'b11, 5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vec[3]  = '{1'b1, 5'd7, 32'h11111111,1'b1, 5'd7, 32'h22222222,2'b01, 5'd7,  5'd3,  32'h22222222, 32'h0,        32'h22222222, 32'h0};
    vec[4]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       2'b11, 5'd7,  5'd3,  32'h22222222, 32'hDEADBEEF, 32'h22222222, 32'hDEADBEEF};
    vec[5]  = '{1'b0, 5'd0, 32'h0,       1'b1, 5'd0, 32'hFFFFFFFF,2'b11, 5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vec[6]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       2'b11, 5'd0,  5'd7,  32'h0,        32'h22222222, 32'hFFFFFFFF, 32'h22222222};
    vec[7]  = '{1'b1, 5'd10,32'h0000AAAA,1'b1, 5'd11,32'h0000BBBB,2'b11, 5'd10, 5'd11, 32'h0000AAAA, 32'h0000BBBB, 32'h0000AAAA, 32'h0000BBBB};
    vec[8]  = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       2'b10, 5'd10, 5'd10, 32'h0,        32'h0000AAAA, 32'h0,        32'h0000AAAA};
    vec[9]  = '{1'b1, 5'd4, 32'h00001234,1'b0, 5'd0, 32'h0,       2'b11, 5'd11, 5'd4,  32'h0000BBBB, 32'h00001234, 32'h0000BBBB, 32'h00001234};
    vec[10] = '{1'b1, 5'd12,32'h0C0C0C0C,1'b0, 5'd0, 32'h0,       2'b11, 5'd3,  5'd12, 32'hDEADBEEF, 32'h0C0C0C0C, 32'hDEADBEEF, 32'h0C0C0C0C};
    vec[11] = '{1'b1, 5'd0, 32'h00000055,1'b0, 5'd0, 32'h0,       2'b01, 5'd0,  5'd0,  32'h0,        32'h0,        32'h00000055, 32'h0};
    vec[12] = '{1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,       2'b11, 5'd0,  5'd4,  32'h0,        32'h00001234, 32'h00000055, 32'h00001234};

    // Reset state.
    idle_inputs();
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    chk("rst_rd_z1", rd_z1[31:0] | rd_z1[63:32], '0);
    chk("rst_rd_z0", rd_z0[31:0] | rd_z0[63:32], '0);
    chk("rst_busy", {31'd0, busy_z1}, 32'd1);

    // Release between edges; read addr 5 on all ports and try to write
    // addr 9 while clearing.
    reset = 1'b0;
    re = 2'b11; ra0 = 5'd5; ra1 = 5'd5;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5A5A5A5;
    run_init("init1");

    // Table-driven READY vectors through the scoreboard queue.
    for (int i = 0; i < NV; i++) begin
      we0 = vec[i].we0; wa0 = vec[i].wa0; wd0 = vec[i].wd0;
      we1 = vec[i].we1; wa1 = vec[i].wa1; wd1 = vec[i].wd1;
      re  = vec[i].re;  ra0 = vec[i].ra0; ra1 = vec[i].ra1;
      sb.push_back('{vec[i].e0, vec[i].e1, vec[i].f0, vec[i].f1});
      @(posedge clock); #1;
      x = sb.pop_front();
      chk($sformatf("v%0d_z1_p0", i), rd_z1[0*DATA_W +: DATA_W], x.e0);
      chk($sformatf("v%0d_z1_p1", i), rd_z1[1*DATA_W +: DATA_W], x.e1);
      chk($sformatf("v%0d_z0_p0", i), rd_z0[0*DATA_W +: DATA_W], x.f0);
      chk($sformatf("v%0d_z0_p1", i), rd_z0[1*DATA_W +: DATA_W], x.f1);
    end

    // Reset mid-operation: addr 4 holds 0x1234, then reset between edges.
    idle_inputs();
    re = 2'b11; ra0 = 5'd4; ra1 = 5'd4;
    @(posedge clock); #1;
    chk("pre_rst_p0", rd_z1[0*DATA_W +: DATA_W], 32'h00001234);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_p0", rd_z1[0*DATA_W +: DATA_W], '0);
    chk("async_rst_p1", rd_z1[1*DATA_W +: DATA_W], '0);
    chk("async_rst_busy", {31'd0, busy_z1}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    run_init("init2");
    @(posedge clock); #1;
    chk("post_rst_addr4_p0", rd_z1[0*DATA_W +: DATA_W], '0);
    chk("post_rst_addr4_z0", rd_z0[1*DATA_W +: DATA_W], '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
